// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch responder.
package ibex_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_entry_t;

endpackage

// File: rtl/ibex_instr_resp_fifo.sv
// In-order response queue: every entry ages from push and becomes poppable
// once its age equals Latency.
module ibex_instr_resp_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter int unsigned Latency = 1,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  resp_entry_t     push_data,
  input  logic            pop,
  output logic            head_ready,
  output resp_entry_t     head_data,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned AgeW = $clog2(Latency + 1);

  resp_entry_t           data_q  [Depth];
  logic [AgeW-1:0]       age_q   [Depth];
  logic [Depth-1:0]      valid_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head_ready = valid_q[rd_ptr_q] && (age_q[rd_ptr_q] == AgeW'(Latency));
  assign head_data  = data_q[rd_ptr_q];
  assign count      = count_q;
  assign do_pop     = pop & head_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (valid_q[i] && (age_q[i] != AgeW'(Latency))) begin
          age_q[i] <= age_q[i] + AgeW'(1);
        end
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      // Push comes last so a push into the slot being popped (full queue) wins.
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        age_q[wr_ptr_q]   <= AgeW'(1);
        data_q[wr_ptr_q]  <= push_data;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_instr_responder.sv
// Memory-side responder for the instruction fetch bus with a loadable
// internal memory, fixed response latency and an outstanding-request limit.
module ibex_instr_responder
  import ibex_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned IdxW          = $clog2(MemWords),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_req_i,
  input  logic [31:0]     instr_addr_i,
  output logic            instr_gnt_o,
  output logic            instr_rvalid_o,
  output logic [31:0]     instr_rdata_o,
  output logic            instr_err_o,
  input  logic            gnt_stall_i,
  input  logic            load_we_i,
  input  logic [IdxW-1:0] load_addr_i,
  input  logic [31:0]     load_wdata_i,
  output logic [CntW-1:0] outstanding_o
);

  localparam logic [32:0] RangeBytes = 33'(MemWords) << 2;

  logic [31:0]     mem [MemWords];
  logic [31:0]     offset;
  logic            in_range;
  logic            addr_err;
  logic [IdxW-1:0] word_idx;
  resp_entry_t     push_data;
  resp_entry_t     head_data;
  logic            head_ready;
  logic [CntW-1:0] count;

  // Addresses below BaseAddr wrap to large offsets and fall out of range.
  assign offset   = instr_addr_i - BaseAddr;
  assign in_range = {1'b0, offset} < RangeBytes;
  assign addr_err = (instr_addr_i[1:0] != 2'b00) | ~in_range;
  assign word_idx = offset[IdxW+1:2];

  assign instr_gnt_o = instr_req_i & ~gnt_stall_i &
                       ((count < CntW'(MaxOutstanding)) | head_ready);

  always_comb begin
    push_data       = '0;
    push_data.err   = addr_err;
    push_data.rdata = addr_err ? '0 : mem[word_idx];
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  ibex_instr_resp_fifo #(
    .Depth   (MaxOutstanding),
    .Latency (RespLatency)
  ) u_resp_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (instr_gnt_o),
    .push_data  (push_data),
    .pop        (head_ready),
    .head_ready (head_ready),
    .head_data  (head_data),
    .count      (count)
  );

  assign instr_rvalid_o = head_ready;
  assign instr_err_o    = head_ready & head_data.err;
  assign instr_rdata_o  = head_ready ? head_data.rdata : '0;
  assign outstanding_o  = count;

endmodule
